// File: rtl/seven_seg_decoder.sv
`default_nettype none
// seven_seg_decoder: filters a strobed 7-segment pattern until stable, then decodes it
// to a held digit result with valid/ready handshake and a saturating error count. Rev 1.0
module seven_seg_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seg_in,
  input  logic       seg_strobe,
  input  logic       out_ready,
  output logic [2:0] digit,
  output logic       digit_valid,
  output logic       digit_e,
  output logic       digit_err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILTER  = 2'd1,
    HOLD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [3:0] c_stable = 4'(STABLE_CYCLES);

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] digit_q, digit_d;
  logic       e_q, e_d;
  logic       err_q, err_d;
  logic       valid_q, valid_d;
  logic [7:0] err_count_q, err_count_d;
  logic       hold_load;
  logic [7:0] load_pat;
  logic [4:0] dec;

  // Returns {err, e, digit}; only exact 8-bit matches decode, so a set dp bit is an error.
  function automatic logic [4:0] decode(input logic [7:0] pat);
    case (pat)
      8'h3F:   decode = 5'b00_000;
      8'h06:   decode = 5'b00_001;
      8'h5B:   decode = 5'b00_010;
      8'h4F:   decode = 5'b00_011;
      8'h66:   decode = 5'b00_100;
      8'h6D:   decode = 5'b00_101;
      8'h79:   decode = 5'b01_110;
      default: decode = 5'b10_000;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    cnt_d       = cnt_q;
    digit_d     = digit_q;
    e_d         = e_q;
    err_d       = err_q;
    valid_d     = valid_q;
    err_count_d = err_count_q;
    hold_load   = 1'b0;
    load_pat    = shadow_q;

    case (state_q)
      IDLE: begin
        if (seg_strobe) begin
          shadow_d = seg_in;
          cnt_d    = 4'd1;
          if (c_stable == 4'd1) begin
            state_d   = HOLD;
            hold_load = 1'b1;
            load_pat  = seg_in;
          end else begin
            state_d = FILTER;
          end
        end
      end
      FILTER: begin
        if (!seg_strobe) begin
          state_d = IDLE;
        end else if (seg_in == shadow_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_d == c_stable) begin
            state_d   = HOLD;
            hold_load = 1'b1;
          end
        end else begin
          shadow_d = seg_in;
          cnt_d    = 4'd1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = seg_strobe ? RELEASE : IDLE;
        end
      end
      RELEASE: begin
        // Wait for the strobe to drop so one assertion yields at most one result.
        if (!seg_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    dec = decode(load_pat);
    if (hold_load) begin
      digit_d = dec[2:0];
      e_d     = dec[3];
      err_d   = dec[4];
      valid_d = 1'b1;
      if (dec[4] && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shadow_q    <= 8'h00;
      cnt_q       <= 4'd0;
      digit_q     <= 3'd0;
      e_q         <= 1'b0;
      err_q       <= 1'b0;
      valid_q     <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      e_q         <= e_d;
      err_q       <= err_d;
      valid_q     <= valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign digit       = digit_q;
  assign digit_e     = e_q;
  assign digit_err   = err_q;
  assign digit_valid = valid_q;
  assign err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_decoder.sv
`default_nettype none
// tb_seven_seg_decoder: directed vectors for the filtered 7-segment decoder.
// Rev 1.0
module tb_seven_seg_decoder;

  logic       clk;
  logic       rst;
  logic [7:0] seg_in;
  logic       seg_strobe;
  logic       out_ready;
  logic [2:0] digit;
  logic       digit_valid;
  logic       digit_e;
  logic       digit_err;
  logic [7:0] err_count;
  logic [2:0] digit1;
  logic       digit_valid1;
  logic       digit_e1;
  logic       digit_err1;
  logic [7:0] err_count1;

  int vectors     = 0;
  int miscompares = 0;

  seven_seg_decoder #(.STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_strobe(seg_strobe),
    .out_ready(out_ready), .digit(digit), .digit_valid(digit_valid),
    .digit_e(digit_e), .digit_err(digit_err), .err_count(err_count)
  );

  seven_seg_decoder #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .seg_in(seg_in), .seg_strobe(seg_strobe),
    .out_ready(out_ready), .digit(digit1), .digit_valid(digit_valid1),
    .digit_e(digit_e1), .digit_err(digit_err1), .err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe assertion held for four edges, then released; ready is high.
  task automatic one_result(input logic [7:0] pat, input logic [2:0] ed,
                            input logic ee, input logic eerr, input string tag);
    seg_in     = pat;
    seg_strobe = 1'b1;
    repeat (4) step();
    chk({tag, "_valid"}, 32'(digit_valid), 32'd1);
    chk({tag, "_digit"}, 32'(digit), 32'(ed));
    chk({tag, "_e"}, 32'(digit_e), 32'(ee));
    chk({tag, "_err"}, 32'(digit_err), 32'(eerr));
    seg_strobe = 1'b0;
    step();
    chk({tag, "_accepted"}, 32'(digit_valid), 32'd0);
  endtask

  initial begin
    int ones;
    logic [7:0] pats [8];

    rst        = 1'b1;
    seg_in     = 8'h00;
    seg_strobe = 1'b0;
    out_ready  = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(digit_valid), 32'd0);
    chk("rst_digit", 32'(digit), 32'd0);
    chk("rst_e", 32'(digit_e), 32'd0);
    chk("rst_err", 32'(digit_err), 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);
    chk("rst_valid_s1", 32'(digit_valid1), 32'd0);
    rst = 1'b0;
    step();

    // 0x5B held six edges: valid right after the 4th edge, exactly one result
    out_ready = 1'b1;
    seg_in    = 8'h5B;
    ones      = 0;
    for (int i = 1; i <= 8; i++) begin
      seg_strobe = (i <= 6);
      step();
      ones += int'(digit_valid);
      if (i == 1) begin
        chk("s1_valid_first_edge", 32'(digit_valid1), 32'd1);
        chk("s1_digit", 32'(digit1), 32'd2);
      end
      if (i == 3) chk("t1_valid_edge3", 32'(digit_valid), 32'd0);
      if (i == 4) begin
        chk("t1_valid_edge4", 32'(digit_valid), 32'd1);
        chk("t1_digit", 32'(digit), 32'd2);
        chk("t1_e", 32'(digit_e), 32'd0);
        chk("t1_err", 32'(digit_err), 32'd0);
      end
    end
    chk("t1_one_result", 32'(ones), 32'd1);

    // Unstable 0x06 prefix is discarded; 0x4F decodes to 3
    pats = '{8'h06, 8'h06, 8'h4F, 8'h4F, 8'h4F, 8'h4F, 8'h00, 8'h00};
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      seg_in     = pats[i];
      seg_strobe = (i < 6);
      step();
      ones += int'(digit_valid);
      if (i == 4) chk("t2_no_early", 32'(digit_valid), 32'd0);
      if (i == 5) chk("t2_digit", 32'(digit), 32'd3);
    end
    chk("t2_one_result", 32'(ones), 32'd1);

    one_result(8'h79, 3'd6, 1'b1, 1'b0, "t3_79");
    one_result(8'hFF, 3'd0, 1'b0, 1'b1, "t3_FF");
    one_result(8'hBF, 3'd0, 1'b0, 1'b1, "t3_BF");
    chk("t3_errcnt", 32'(err_count), 32'd2);

    // Result held while out_ready is low and inputs wander
    out_ready  = 1'b0;
    seg_in     = 8'h66;
    seg_strobe = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      seg_in     = 8'(i * 17 + 1);
      seg_strobe = i[0];
      step();
      chk("t4_hold_valid", 32'(digit_valid), 32'd1);
      chk("t4_hold_digit", 32'(digit), 32'd4);
    end
    out_ready  = 1'b1;
    seg_strobe = 1'b0;
    step();
    chk("t4_accept", 32'(digit_valid), 32'd0);
    chk("t4_digit_kept", 32'(digit), 32'd4);

    // Strobe dropped after two matching samples: no result
    seg_in     = 8'h3F;
    seg_strobe = 1'b1;
    repeat (2) step();
    seg_strobe = 1'b0;
    ones = 0;
    repeat (5) begin
      step();
      ones += int'(digit_valid);
    end
    chk("t5_abort_none", 32'(ones), 32'd0);
    chk("t5_errcnt", 32'(err_count), 32'd2);

    // Reset while holding a result
    out_ready  = 1'b0;
    seg_in     = 8'h79;
    seg_strobe = 1'b1;
    repeat (4) step();
    chk("t6_hold_valid", 32'(digit_valid), 32'd1);
    chk("t6_hold_digit", 32'(digit), 32'd6);
    rst = 1'b1;
    step();
    chk("t6_rst_valid", 32'(digit_valid), 32'd0);
    chk("t6_rst_digit", 32'(digit), 32'd0);
    chk("t6_rst_e", 32'(digit_e), 32'd0);
    chk("t6_rst_err", 32'(digit_err), 32'd0);
    chk("t6_rst_errcnt", 32'(err_count), 32'd0);
    rst        = 1'b0;
    seg_strobe = 1'b0;
    step();

    // 300 invalid results saturate err_count
    out_ready = 1'b1;
    for (int n = 1; n <= 300; n++) begin
      seg_in     = 8'h86;
      seg_strobe = 1'b1;
      repeat (4) step();
      if (n == 1) begin
        chk("t7_dp_digit", 32'(digit), 32'd0);
        chk("t7_dp_e", 32'(digit_e), 32'd0);
        chk("t7_dp_err", 32'(digit_err), 32'd1);
      end
      seg_strobe = 1'b0;
      step();
      if (n == 254) chk("t7_errcnt_254", 32'(err_count), 32'd254);
      if (n == 255) chk("t7_errcnt_255", 32'(err_count), 32'd255);
    end
    chk("t7_errcnt_sat", 32'(err_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_decoder.md
SEVEN_SEG_DECODER -- requirements
Module: seven_seg_decoder

Interface
REQ-001: Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before decode; legal range 1..15.
REQ-002: clk  input  1  single clock; all logic updates on its rising edge.
REQ-003: rst  input  1  reset, synchronous and active-high.
REQ-004: seg_in  input  8  segment pattern, bit0=a .. bit6=g, bit7=dp, active-high.
REQ-005: seg_strobe  input  1  high while seg_in carries a pattern to decode.
REQ-006: out_ready  input  1  consumer accepts the result when high with digit_valid.
REQ-007: digit  output  3  decoded value.
REQ-008: digit_valid  output  1  result available; held until accepted.
REQ-009: digit_e  output  1  pattern was the "E" (value >= 6) glyph.
REQ-010: digit_err  output  1  pattern matched no table entry.
REQ-011: err_count  output  8  saturating count of digit_err results.

Function
REQ-012: Decode table SHALL be exact 8-bit matches: 0x3F->0, 0x06->1, 0x5B->2, 0x4F->3, 0x66->4, 0x6D->5, 0x79->digit 3'b110 with digit_e=1.
REQ-013: Any other pattern, including a table pattern with bit7 set, SHALL give digit=0, digit_e=0, digit_err=1.
REQ-014: FSM states SHALL be IDLE, FILTER, HOLD, RELEASE.
REQ-015: IDLE: on a sampled seg_strobe=1, capture seg_in into a shadow register and set the match counter to 1; go to FILTER, or directly to HOLD if STABLE_CYCLES=1.
REQ-016: FILTER, seg_strobe=1, seg_in==shadow: increment counter; when it reaches STABLE_CYCLES, go to HOLD.
REQ-017: FILTER, seg_strobe=1, seg_in!=shadow: recapture the shadow, reset counter to 1, stay in FILTER.
REQ-018: FILTER, seg_strobe=0: return to IDLE; no result and no err_count change.
REQ-019: On the HOLD entry edge: register digit/digit_e/digit_err from the shadow and set digit_valid=1; digit_valid therefore rises after the STABLE_CYCLES-th sampling edge, counting the capture edge as the first.
REQ-020: HOLD: digit, digit_e and digit_err SHALL stay constant; seg_in and seg_strobe are ignored.
REQ-021: HOLD with out_ready=1 on an edge: clear digit_valid; go to RELEASE if seg_strobe=1, otherwise to IDLE.
REQ-022: RELEASE: wait for seg_strobe=0, then go to IDLE, so one strobe assertion yields at most one result.
REQ-023: err_count SHALL increment by 1 on each HOLD entry with digit_err=1 and saturate at 255.
REQ-024: digit, digit_e and digit_err SHALL keep their last values after acceptance and are meaningful only while digit_valid=1.
REQ-025: out_ready is ignored outside HOLD.

Reset
REQ-026: rst=1 on an edge SHALL force IDLE and set digit=0, digit_valid=0, digit_e=0, digit_err=0, err_count=0, shadow=0, and match counter=0.
REQ-027: rst SHALL take priority over every other condition in every state, aborting any filter or pending result without incrementing err_count.

Verification
REQ-028: STABLE_CYCLES=4; seg_in=0x5B with strobe high for 6 cycles; out_ready=1 -> digit_valid high exactly one cycle after the 4th sampling edge, digit=2, digit_e=0, digit_err=0; exactly one result.
REQ-029: seg_in=0x06,0x06,0x4F,0x4F,0x4F,0x4F with strobe high -> single result digit=3; the 0x06 prefix produces nothing.
REQ-030: seg_in=0x79, then 0xFF, then 0xBF, each a separate strobe assertion -> results (6, e=1), (err=1), (err=1); err_count=2.
REQ-031: out_ready held 0 for 10 cycles during HOLD while seg_in changes -> digit_valid and digit stay constant; accepted on the first out_ready=1 edge.
REQ-032: Strobe dropped after 2 matching samples -> no result; rst asserted in HOLD -> all outputs 0 on the next edge; 300 invalid results -> err_count=255.
